// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the default table depth.
package bp_pkg;

  localparam int BHT_ENTRIES_DEFAULT = 16;

  // Saturating direction counter: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline (master) and the branch predictor (slave).
// Optional build macro: BP_STATS_EN adds the branch/mispredict statistics outputs.
interface branch_predictor_if;

  logic [31:0] PcIf;
  logic        PredTakenIf;
  logic [31:0] PredTargetIf;
  logic        BranchValidEx;
  logic        BranchEx;
  logic [31:0] PcEx;
  logic [31:0] TargetEx;
  logic        PredTakenEx;
  logic [31:0] PredTargetEx;
  logic        FlushEx;
  logic        MispredictEx;
  logic [31:0] RedirectPcEx;
`ifdef BP_STATS_EN
  logic [31:0] BranchCntOut;
  logic [31:0] MispredCntOut;
`endif

  modport master (
    output PcIf, BranchValidEx, BranchEx, PcEx, TargetEx,
           PredTakenEx, PredTargetEx, FlushEx,
    input  PredTakenIf, PredTargetIf, MispredictEx, RedirectPcEx
`ifdef BP_STATS_EN
    , BranchCntOut, MispredCntOut
`endif
  );

  modport slave (
    input  PcIf, BranchValidEx, BranchEx, PcEx, TargetEx,
           PredTakenEx, PredTargetEx, FlushEx,
    output PredTakenIf, PredTargetIf, MispredictEx, RedirectPcEx
`ifdef BP_STATS_EN
    , BranchCntOut, MispredCntOut
`endif
  );

endinterface

// File: rtl/bp_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_counter2
  import bp_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e next
);

  // Step one state toward taken or not-taken, saturating at ST and SNT.
  always_comb begin
    next = cur;
    case (cur)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// IF side looks up combinationally (no bypass of a same-cycle EX write);
// EX side trains the table and raises a redirect on a wrong prediction.
// Optional build macro: BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT
)
(
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_r  [BHT_ENTRIES];
  logic [TAG_W-1:0] tag_r    [BHT_ENTRIES];
  logic [31:0]      target_r [BHT_ENTRIES];
  ctr_e             ctr_r    [BHT_ENTRIES];

  logic [IDX_W-1:0] if_idx_s;
  logic [TAG_W-1:0] if_tag_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [TAG_W-1:0] ex_tag_s;
  logic             upd_s;
  logic             ex_hit_s;
  ctr_e             ctr_step_s;
  ctr_e             ctr_new_s;
  logic             ctr_wr_s;
  logic             entry_wr_s;
  logic             unused_pc_bits_s;

  assign if_idx_s = bus.PcIf[IDX_W+1:2];
  assign if_tag_s = bus.PcIf[31:IDX_W+2];
  assign ex_idx_s = bus.PcEx[IDX_W+1:2];
  assign ex_tag_s = bus.PcEx[31:IDX_W+2];

  // Instructions are word aligned, so the byte offset never selects anything.
  assign unused_pc_bits_s = ^{bus.PcIf[1:0], bus.PcEx[1:0]};

  // Fetch lookup reads the registered table, so a same-cycle update is not visible.
  assign bus.PredTakenIf  = valid_r[if_idx_s] & (tag_r[if_idx_s] == if_tag_s) & ctr_r[if_idx_s][1];
  assign bus.PredTargetIf = target_r[if_idx_s];

  assign upd_s    = bus.BranchValidEx & ~bus.FlushEx;
  assign ex_hit_s = valid_r[ex_idx_s] & (tag_r[ex_idx_s] == ex_tag_s);

  bp_counter2 u_counter2 (
    .cur   (ctr_r[ex_idx_s]),
    .taken (bus.BranchEx),
    .next  (ctr_step_s)
  );

  // Decide what the EX branch writes: train on a hit, allocate on a taken miss.
  always_comb begin
    ctr_wr_s   = 1'b0;
    entry_wr_s = 1'b0;
    ctr_new_s  = ctr_step_s;
    if (upd_s) begin
      if (ex_hit_s) begin
        ctr_wr_s   = 1'b1;
        entry_wr_s = bus.BranchEx;
        ctr_new_s  = ctr_step_s;
      end else if (bus.BranchEx) begin
        ctr_wr_s   = 1'b1;
        entry_wr_s = 1'b1;
        ctr_new_s  = WT;
      end else begin
        ctr_wr_s   = 1'b0;
        entry_wr_s = 1'b0;
        ctr_new_s  = ctr_step_s;
      end
    end else begin
      ctr_wr_s   = 1'b0;
      entry_wr_s = 1'b0;
      ctr_new_s  = ctr_step_s;
    end
  end

  assign bus.MispredictEx = upd_s & ((bus.PredTakenEx != bus.BranchEx) |
                                     (bus.BranchEx & bus.PredTakenEx &
                                      (bus.PredTargetEx != bus.TargetEx)));
  assign bus.RedirectPcEx = bus.BranchEx ? bus.TargetEx : (bus.PcEx + 32'd4);

  // Valid bits and counters: cleared to invalid / weakly-not-taken by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= WNT;
      end
    end else begin
      if (ctr_wr_s) begin
        ctr_r[ex_idx_s] <= ctr_new_s;
      end
      if (entry_wr_s) begin
        valid_r[ex_idx_s] <= 1'b1;
      end
    end
  end

  // Tag and target payload; meaningless while the entry is invalid, so no reset.
  always_ff @(posedge clk) begin
    if (entry_wr_s) begin
      tag_r[ex_idx_s]    <= ex_tag_s;
      target_r[ex_idx_s] <= bus.TargetEx;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_r;
  logic [31:0] mispred_cnt_r;

  // Saturating counts of resolved branches and of redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_r  <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      if (upd_s && (branch_cnt_r != 32'hFFFF_FFFF)) begin
        branch_cnt_r <= branch_cnt_r + 32'd1;
      end
      if (bus.MispredictEx && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
        mispred_cnt_r <= mispred_cnt_r + 32'd1;
      end
    end
  end

  assign bus.BranchCntOut  = branch_cnt_r;
  assign bus.MispredCntOut = mispred_cnt_r;
`else
  // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run checked against a behavioural table model.
// Optional build macro: BP_STATS_EN enables the statistics checks.
module tb_branch_predictor;

  localparam int N    = 16;
  localparam int LOGN = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.BHT_ENTRIES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bp_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the table.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int unsigned m_branches;
  int unsigned m_mispreds;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (2 + LOGN);
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    int unsigned i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return m_tgt[idx_of(pc)];
  endfunction

  function automatic bit exp_mis();
    bit upd;
    upd = bp_if.BranchValidEx && !bp_if.FlushEx;
    if (!upd) return 1'b0;
    if (bp_if.PredTakenEx != bp_if.BranchEx) return 1'b1;
    return bp_if.BranchEx && bp_if.PredTakenEx && (bp_if.PredTargetEx != bp_if.TargetEx);
  endfunction

  function automatic logic [31:0] exp_redirect();
    return bp_if.BranchEx ? bp_if.TargetEx : bp_if.PcEx + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_branches = 0;
    m_mispreds = 0;
  endfunction

  function automatic void model_commit();
    int unsigned i;
    bit hit;
    if (bp_if.BranchValidEx && !bp_if.FlushEx) begin
      m_branches++;
      if (exp_mis()) m_mispreds++;
      i   = idx_of(bp_if.PcEx);
      hit = m_valid[i] && (m_tag[i] == tag_of(bp_if.PcEx));
      if (hit) begin
        if (bp_if.BranchEx) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = bp_if.TargetEx;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (bp_if.BranchEx) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(bp_if.PcEx);
        m_tgt[i]   = bp_if.TargetEx;
        m_ctr[i]   = 2;
      end
    end
  endfunction

  task automatic drive(input logic [31:0] pc_if, input bit bv, input bit br,
                       input logic [31:0] pc_ex, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptgt, input bit fl);
    bp_if.PcIf          = pc_if;
    bp_if.BranchValidEx = bv;
    bp_if.BranchEx      = br;
    bp_if.PcEx          = pc_ex;
    bp_if.TargetEx      = tgt;
    bp_if.PredTakenEx   = pt;
    bp_if.PredTargetEx  = ptgt;
    bp_if.FlushEx       = fl;
    #1;
  endtask

  task automatic idle(input logic [31:0] pc_if);
    drive(pc_if, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(32'h0040_0010);
    #10;
    checks++;
    if (bp_if.PredTakenIf !== 1'b0) begin
      errors++; $display("FAIL reset_pred got %b exp 0", bp_if.PredTakenIf);
    end
    checks++;
    if (bp_if.MispredictEx !== 1'b0) begin
      errors++; $display("FAIL reset_mis got %b exp 0", bp_if.MispredictEx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(32'h0040_0010);
    checks++;
    if (bp_if.PredTakenIf !== 1'b0) begin
      errors++; $display("FAIL post_reset_lookup got %b exp 0", bp_if.PredTakenIf);
    end
`ifdef BP_STATS_EN
    checks++;
    if (bp_if.BranchCntOut !== 32'd0 || bp_if.MispredCntOut !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", bp_if.BranchCntOut, bp_if.MispredCntOut);
    end
`endif
  endtask

  task automatic test_alloc();
    drive(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
    checks++;
    if (bp_if.PredTakenIf !== 1'b0) begin
      errors++; $display("FAIL no_bypass got %b exp 0", bp_if.PredTakenIf);
    end
    checks++;
    if (bp_if.MispredictEx !== 1'b1 || bp_if.RedirectPcEx !== 32'h0040_0100) begin
      errors++; $display("FAIL alloc_redirect got %b/%h exp 1/00400100", bp_if.MispredictEx, bp_if.RedirectPcEx);
    end
    step();
    idle(32'h0040_0010);
    checks++;
    if (bp_if.PredTakenIf !== 1'b1 || bp_if.PredTargetIf !== 32'h0040_0100) begin
      errors++; $display("FAIL alloc_lookup got %b/%h exp 1/00400100", bp_if.PredTakenIf, bp_if.PredTargetIf);
    end
  endtask

  task automatic test_not_taken_decay();
    bit pts [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0100, pts[k], 32'h0040_0100, 1'b0);
      checks++;
      if (bp_if.MispredictEx !== pts[k]) begin
        errors++; $display("FAIL decay_mis%0d got %b exp %b", k, bp_if.MispredictEx, pts[k]);
      end
      if (k == 1) begin
        checks++;
        if (bp_if.RedirectPcEx !== 32'h0040_0014) begin
          errors++; $display("FAIL decay_redirect got %h exp 00400014", bp_if.RedirectPcEx);
        end
      end
      step();
      idle(32'h0040_0010);
      checks++;
      if (bp_if.PredTakenIf !== 1'b0) begin
        errors++; $display("FAIL decay_pred%0d got %b exp 0", k, bp_if.PredTakenIf);
      end
    end
    // Counter now at SNT: one taken reaches WNT (still not taken), second reaches WT.
    for (int k = 0; k < 2; k++) begin
      drive(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
      step();
      idle(32'h0040_0010);
      checks++;
      if (bp_if.PredTakenIf !== (k == 1)) begin
        errors++; $display("FAIL climb_pred%0d got %b exp %b", k, bp_if.PredTakenIf, (k == 1));
      end
    end
  endtask

  task automatic test_flush();
    drive(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_0200, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bp_if.MispredictEx !== 1'b0) begin
      errors++; $display("FAIL flush_mis got %b exp 0", bp_if.MispredictEx);
    end
    step();
    idle(32'h0040_0010);
    checks++;
    if (bp_if.PredTakenIf !== 1'b1 || bp_if.PredTargetIf !== 32'h0040_0100) begin
      errors++; $display("FAIL flush_entry got %b/%h exp 1/00400100", bp_if.PredTakenIf, bp_if.PredTargetIf);
    end
    // Counter was not bumped by the flushed branch: one not-taken drops below WT.
    drive(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0010, 32'h0, 1'b1, 32'h0040_0100, 1'b0);
    step();
    idle(32'h0040_0010);
    checks++;
    if (bp_if.PredTakenIf !== 1'b0) begin
      errors++; $display("FAIL flush_counter got %b exp 0", bp_if.PredTakenIf);
    end
  endtask

  task automatic test_alias();
    drive(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0050, 32'h0040_0300, 1'b0, 32'h0, 1'b0);
    checks++;
    if (bp_if.MispredictEx !== 1'b1 || bp_if.RedirectPcEx !== 32'h0040_0300) begin
      errors++; $display("FAIL alias_redirect got %b/%h exp 1/00400300", bp_if.MispredictEx, bp_if.RedirectPcEx);
    end
    step();
    idle(32'h0040_0010);
    checks++;
    if (bp_if.PredTakenIf !== 1'b0) begin
      errors++; $display("FAIL alias_old_miss got %b exp 0", bp_if.PredTakenIf);
    end
    idle(32'h0040_0050);
    checks++;
    if (bp_if.PredTakenIf !== 1'b1 || bp_if.PredTargetIf !== 32'h0040_0300) begin
      errors++; $display("FAIL alias_new_hit got %b/%h exp 1/00400300", bp_if.PredTakenIf, bp_if.PredTargetIf);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2);
    return pc;
  endfunction

  task automatic test_random();
    logic [31:0] pc_if, pc_ex, tgt, ptgt;
    bit bv, br, pt, fl;
    for (int c = 0; c < 400; c++) begin
      pc_ex = rand_pc();
      pc_if = ($urandom_range(0, 3) == 0) ? pc_ex : rand_pc();
      bv    = ($urandom_range(0, 9) < 7);
      br    = $urandom_range(0, 1);
      fl    = ($urandom_range(0, 4) == 0);
      tgt   = ($urandom_range(0, 1) == 1) ? exp_target(pc_ex) : 32'h0040_0000 | ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 1) == 1) begin
        pt = exp_taken(pc_ex);
      end else begin
        pt = $urandom_range(0, 1);
      end
      ptgt = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
      drive(pc_if, bv, br, pc_ex, tgt, pt, ptgt, fl);
      checks++;
      if (bp_if.PredTakenIf !== exp_taken(pc_if)) begin
        errors++; $display("FAIL rnd_pred c=%0d pc=%h got %b exp %b", c, pc_if, bp_if.PredTakenIf, exp_taken(pc_if));
      end
      if (exp_taken(pc_if)) begin
        checks++;
        if (bp_if.PredTargetIf !== exp_target(pc_if)) begin
          errors++; $display("FAIL rnd_target c=%0d got %h exp %h", c, bp_if.PredTargetIf, exp_target(pc_if));
        end
      end
      checks++;
      if (bp_if.MispredictEx !== exp_mis()) begin
        errors++; $display("FAIL rnd_mis c=%0d got %b exp %b", c, bp_if.MispredictEx, exp_mis());
      end
      checks++;
      if (bp_if.RedirectPcEx !== exp_redirect()) begin
        errors++; $display("FAIL rnd_redirect c=%0d got %h exp %h", c, bp_if.RedirectPcEx, exp_redirect());
      end
`ifdef BP_STATS_EN
      checks++;
      if (bp_if.BranchCntOut !== m_branches || bp_if.MispredCntOut !== m_mispreds) begin
        errors++; $display("FAIL rnd_stats c=%0d got %0d/%0d exp %0d/%0d", c,
                           bp_if.BranchCntOut, bp_if.MispredCntOut, m_branches, m_mispreds);
      end
`endif
      step();
    end
    // Wrap of the fall-through address.
    drive(32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b0);
    checks++;
    if (bp_if.RedirectPcEx !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_redirect got %h exp 00000000", bp_if.RedirectPcEx);
    end
    step();
  endtask

  task automatic test_async_reset();
    drive(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0020, 32'h0040_0400, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    idle(32'h0040_0050);
    checks++;
    if (bp_if.PredTakenIf !== 1'b0 || bp_if.MispredictEx !== 1'b0) begin
      errors++; $display("FAIL async_reset_out got %b/%b exp 0/0", bp_if.PredTakenIf, bp_if.MispredictEx);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(32'h0040_0020);
    checks++;
    if (bp_if.PredTakenIf !== 1'b0) begin
      errors++; $display("FAIL async_reset_discard got %b exp 0", bp_if.PredTakenIf);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    bit          brs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit          pts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] pc;
    for (int k = 0; k < 5; k++) begin
      pc = 32'h0040_1000 + (k * 4);
      drive(pc, 1'b1, brs[k], pc, 32'h0040_2000, pts[k], 32'h0040_2000, 1'b0);
      step();
    end
    idle(32'h0);
    checks++;
    if (bp_if.BranchCntOut !== 32'd5 || bp_if.MispredCntOut !== 32'd2) begin
      errors++; $display("FAIL stats_count got %0d/%0d exp 5/2", bp_if.BranchCntOut, bp_if.MispredCntOut);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bp_if.BranchCntOut !== 32'd0 || bp_if.MispredCntOut !== 32'd0) begin
      errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", bp_if.BranchCntOut, bp_if.MispredCntOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_alloc();
    test_not_taken_decay();
    test_flush();
    test_alias();
    test_random();
    test_async_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of direct-mapped entries (power of two, 4..64).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PcIf, input, 32, fetch-stage PC to predict.
REQ-005 SHALL have port PredTakenIf, output, 1, fetch-stage taken prediction.
REQ-006 SHALL have port PredTargetIf, output, 32, predicted target, valid when PredTakenIf=1.
REQ-007 SHALL have port BranchValidEx, input, 1, EX holds a conditional branch (BEQ/BNE/BLEZ/BGTZ/REGIMM).
REQ-008 SHALL have port BranchEx, input, 1, resolved outcome from the EX branch-resolution unit.
REQ-009 SHALL have ports PcEx and TargetEx, input, 32 each, EX branch PC and computed target.
REQ-010 SHALL have ports PredTakenEx (1) and PredTargetEx (32), inputs, the prediction piped from IF to EX.
REQ-011 SHALL have port FlushEx, input, 1, exception/interrupt kill of the EX instruction.
REQ-012 SHALL have port MispredictEx, output, 1, redirect request to the hazard unit.
REQ-013 SHALL have port RedirectPcEx, output, 32, correct next PC when MispredictEx=1.

Function
REQ-014 SHALL index the tables with Idx = PC[log2(BHT_ENTRIES)+1:2]; Tag = PC[31:log2(BHT_ENTRIES)+2].
REQ-015 SHALL hold per entry: Valid (1), Tag, Target (32), and a 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 SHALL compute PredTakenIf combinationally as Valid & tag match & Counter[1]; on miss, PredTakenIf=0.
REQ-017 SHALL drive PredTargetIf from the indexed Target; its value is don't-care when PredTakenIf=0.
REQ-018 SHALL define the update condition Upd = BranchValidEx & ~FlushEx; with Upd=0, no state changes and MispredictEx=0.
REQ-019 SHALL, on Upd with BranchEx=1, increment the counter (saturating at 11) and write Valid=1, Tag, Target=TargetEx.
REQ-020 SHALL, on Upd with BranchEx=0, decrement the counter (saturating at 00) and leave Valid, Tag and Target unchanged.
REQ-021 SHALL, on Upd for an entry with a tag mismatch, initialise the counter to 10 if taken (entry allocated), and leave the entry unchanged if not taken.
REQ-022 SHALL assert MispredictEx combinationally = Upd & ((PredTakenEx != BranchEx) | (BranchEx & PredTakenEx & PredTargetEx != TargetEx)).
REQ-023 SHALL set RedirectPcEx = BranchEx ? TargetEx : PcEx+4 (no delay slot), wrapping modulo 2^32.
REQ-024 SHALL, on the same-cycle read (IF) and write (EX) of the same index, return the pre-update value (no bypass).

Reset
REQ-025 SHALL, while rst_n=0, clear all Valid bits and set all counters to 01; Tag and Target are not reset.
REQ-026 SHALL hold all outputs defined during reset: PredTakenIf=0 and, with BranchValidEx=0, MispredictEx=0.
REQ-027 SHALL discard an update in progress when reset asserts mid-cycle.

Configuration
REQ-028 SHALL, with BP_STATS_EN defined, add 32-bit saturating counters BranchCntOut and MispredCntOut (outputs, reset to 0), incremented on Upd and on MispredictEx respectively.
REQ-029 SHALL, without BP_STATS_EN, have no such ports and no related logic.

Structure
REQ-030 SHALL place the counter encodings (SNT/WNT/WT/ST) and the default BHT_ENTRIES in the shared package bp_pkg.
REQ-031 SHALL implement the 2-bit saturating update as the single sub-module bp_counter2 (in: cur, taken; out: next).

Verification
REQ-032 Reset, then PcIf=0x00400010 -> PredTakenIf=0.
REQ-033 Upd taken at PcEx=0x00400010, TargetEx=0x00400100, PredTakenEx=0 -> MispredictEx=1, RedirectPcEx=0x00400100; next cycle PcIf=0x00400010 -> PredTakenIf=1, PredTargetIf=0x00400100.
REQ-034 Three not-taken updates at the same PC after REQ-033 -> counter 10->01->00->00; the second update has PredTakenEx=1 -> MispredictEx=1, RedirectPcEx=0x00400014.
REQ-035 FlushEx=1 with BranchValidEx=1, BranchEx=1 -> MispredictEx=0 and the table is unchanged.
REQ-036 Alias 0x00400050 (same Idx, different Tag) taken -> entry reallocated with counter=10; a lookup at 0x00400010 then misses.
REQ-037 With BP_STATS_EN: 5 updates including 2 mispredicts -> BranchCntOut=5, MispredCntOut=2; async rst_n pulse -> both 0.
